// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcodes, controller states, default width.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_MUL  = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, always WIDTH cycles.
// Operands are captured on start; done is high during the final iteration cycle, and
// product holds the full result from the following cycle until the next start or reset.
module seq_mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Next-state: load on start, otherwise one add/shift step per busy cycle.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Datapath and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked ALU: single-cycle logic/add/sub, iterative multiply, one request in flight.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | multiplier iterating, WIDTH cycles
// DONE  | result valid, waiting for out_ready
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        f,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic              zero,
    output logic              carry,
    output logic              ovf,
    output logic              err
);

    state_e             state_q, state_d;
    logic               is_mul_q, is_mul_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    op_e                op_in;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_err;

    assign op_in    = op_e'(f);
    assign in_ready = (state_q == IDLE) && !rst && !mul_busy;
    assign accept   = in_valid && in_ready;
    assign add_full = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the unsigned borrow.
    assign sub_full = {1'b0, a} - {1'b0, b};

    // Single-cycle result and flags for the non-multiply opcodes.
    always_comb begin
        alu_y     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op_in)
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_NAND: alu_y = ~(a & b);
            OP_NOR:  alu_y = ~(a | b);
            OP_ADD: begin
                alu_y     = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y     = sub_full[WIDTH-1:0];
                alu_carry = sub_full[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ILL:  alu_err = 1'b1;
            default: alu_y = '0;
        endcase
    end

    // Controller next-state; non-multiply results are latched at the accept edge.
    always_comb begin
        state_d   = state_q;
        is_mul_d  = is_mul_q;
        y_d       = y_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_in == OP_MUL) begin
                        state_d   = MUL;
                        is_mul_d  = 1'b1;
                        mul_start = 1'b1;
                    end else begin
                        state_d  = DONE;
                        is_mul_d = 1'b0;
                        y_d      = alu_y;
                        zero_d   = (alu_y == '0);
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        err_d    = alu_err;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            is_mul_q <= 1'b0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_mul_q <= is_mul_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Multiply results come straight from the multiplier, which holds them while idle.
    always_comb begin
        y     = y_q;
        zero  = zero_q;
        carry = carry_q;
        ovf   = ovf_q;
        err   = err_q;
        if ((state_q == DONE) && is_mul_q) begin
            y     = mul_product[WIDTH-1:0];
            zero  = (mul_product[WIDTH-1:0] == '0);
            carry = |mul_product[2*WIDTH-1:WIDTH];
            ovf   = 1'b0;
            err   = 1'b0;
        end
    end

    assign out_valid = (state_q == DONE);

    seq_mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param at WIDTH=32: directed table, random vs model, reset abort.
module tb_alu_seq_param;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    f;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   vf;
        int           hold;
        logic [W-1:0] ey;
        logic         ez;
        logic         ec;
        logic         eo;
        logic         ee;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] v,
                                  output logic [W-1:0] r, output logic z, output logic c,
                                  output logic o, output logic e);
        logic [63:0] u;
        longint      sx, sv, s;
        sx = longint'($signed(x));
        sv = longint'($signed(v));
        r = '0; c = 1'b0; o = 1'b0; e = 1'b0;
        case (op)
            3'd0: r = x & v;
            3'd1: r = x | v;
            3'd2: r = ~(x & v);
            3'd3: r = ~(x | v);
            3'd4: begin
                u = {32'd0, x} + {32'd0, v};
                r = u[31:0];
                c = (u > 64'h0000_0000_FFFF_FFFF);
                s = sx + sv;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd5: begin
                r = x - v;
                c = (x < v);
                s = sx - sv;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd6: begin
                u = {32'd0, x} * {32'd0, v};
                r = u[31:0];
                c = ((u >> 32) != 64'd0);
            end
            default: e = 1'b1;
        endcase
        z = (r == '0);
    endfunction

    // One full transaction: issue, wait for result, check, optional back-pressure, handshake.
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [2:0] tf, input int hold, input logic [W-1:0] ey,
                          input logic ez, input logic ec, input logic eo, input logic ee);
        int           lat;
        logic         rdy_bad;
        logic         stable;
        logic [W-1:0] y0;
        logic [3:0]   fl0;
        @(negedge clk);
        chk({nm, ".in_ready"}, in_ready, 1'b1);
        a = ta; b = tb; f = tf; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; f = 3'($urandom_range(0, 7));
        lat = 0;
        rdy_bad = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_bad = 1'b1;
            if (out_valid) break;
            if (lat > 60) break;
        end
        chk({nm, ".latency"}, lat, (tf == 3'd6) ? 33 : 1);
        chk({nm, ".y"}, y, ey);
        chk({nm, ".flags(zcoe)"}, {zero, carry, ovf, err}, {ez, ec, eo, ee});
        y0 = y;
        fl0 = {zero, carry, ovf, err};
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || y !== y0 || {zero, carry, ovf, err} !== fl0) stable = 1'b0;
            if (in_ready) rdy_bad = 1'b1;
        end
        if (hold > 0) chk({nm, ".held_stable"}, stable, 1'b1);
        chk({nm, ".in_ready_low_while_busy"}, rdy_bad, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] ra, rb, my;
        logic [2:0]   rf;
        logic         mz, mc, mo, me;
        logic         spurious;

        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 3'd4, 0, 32'h0000_0000, 1, 1, 0, 0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 3'd4, 0, 32'h8000_0000, 0, 0, 1, 0});
        vecs.push_back('{32'h0000_0003, 32'h0000_0005, 3'd5, 0, 32'hFFFF_FFFE, 0, 1, 0, 0});
        vecs.push_back('{32'h0001_0000, 32'h0001_0000, 3'd6, 0, 32'h0000_0000, 1, 1, 0, 0});
        vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 5, 32'h0FFF_0FFF, 0, 0, 0, 0});
        vecs.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 3'd7, 0, 32'h0000_0000, 1, 0, 0, 1});
        vecs.push_back('{32'h0000_0001, 32'h0000_0002, 3'd1, 0, 32'h0000_0003, 0, 0, 0, 0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 2, 32'h0000_0001, 0, 1, 0, 0});
        vecs.push_back('{32'h0000_0000, 32'h0001_2345, 3'd6, 0, 32'h0000_0000, 1, 0, 0, 0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 3'd5, 0, 32'h7FFF_FFFF, 0, 0, 1, 0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 3'd3, 0, 32'hFFFF_FFFF, 0, 0, 0, 0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 3'd0, 1, 32'h0000_0000, 1, 0, 0, 0});

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'h5; b = 32'h6; f = 3'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready_during_rst", in_ready, 1'b0);
        chk("reset.outputs", {out_valid, y, zero, carry, ovf, err}, 37'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("reset.in_ready_after", in_ready, 1'b1);
        chk("reset.out_valid_after", out_valid, 1'b0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vf, vecs[i].hold,
                   vecs[i].ey, vecs[i].ez, vecs[i].ec, vecs[i].eo, vecs[i].ee);
        end

        // Reset in the middle of a multiply: no result for the aborted request.
        @(negedge clk);
        a = 32'h0000_0007; b = 32'h0000_0009; f = 3'd6; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort.out_valid_c11", out_valid, 1'b0);
        chk("abort.in_ready_c11", in_ready, 1'b1);
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious = 1'b1;
        end
        chk("abort.no_out_valid", spurious, 1'b0);
        run_op("abort.or", 32'h1, 32'h2, 3'd1, 0, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random requests against the reference model, boundary operands mixed in.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = '1;
                1: rb = '0;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            rf = 3'($urandom_range(0, 7));
            model(rf, ra, rb, my, mz, mc, mo, me);
            run_op($sformatf("rnd%0d_f%0d", n, rf), ra, rb, rf, $urandom_range(0, 2),
                   my, mz, mc, mo, me);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
